mfb_protocol_checker: RTL and testbench
=======================================

MFB_PROTOCOL_CHECKER -- requirements
Module: mfb_protocol_checker

Interface
REQ-001 SHALL have parameter REGIONS, default 4: MFB regions per word.
REQ-002 SHALL have parameter REGION_SIZE, default 8: blocks per region.
REQ-003 SHALL have parameter BLOCK_SIZE, default 8: items per block.
REQ-004 SHALL have parameter ITEM_WIDTH, default 8: item width in bits.
REQ-005 SHALL have parameter META_WIDTH, default 0: metadata bits per region; 0 means no metadata is checked.
REQ-006 SHALL have parameter CNT_WIDTH, default 32: width of both counters.
REQ-007 SHALL have port CLK, input, 1 bit: the only clock.
REQ-008 SHALL have port RESET_N, input, 1 bit: reset, synchronous and active-low.
REQ-009 SHALL have the monitored bus as inputs: DATA (REGIONS*REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH), META (REGIONS*META_WIDTH), SOF and EOF (REGIONS each), SOF_POS (REGIONS*max(1,log2 REGION_SIZE)), EOF_POS (REGIONS*max(1,log2(REGION_SIZE*BLOCK_SIZE))), SRC_RDY (1) and DST_RDY (1).
REQ-010 SHALL have port CLEAR, input, 1 bit: synchronous clear of all status outputs.
REQ-011 SHALL have port ERR_FLAGS, output, 4 bits: sticky flags, bit 0 SOF_IN_PKT, bit 1 EOF_NO_PKT, bit 2 HOLD, bit 3 reserved and always 0.
REQ-012 SHALL have port ERR_CNT, output, CNT_WIDTH bits: saturating count of cycles with at least one error.
REQ-013 SHALL have port PKT_CNT, output, CNT_WIDTH bits: saturating count of accepted EOFs.
REQ-014 SHALL have port FIRST_ERR_VLD, output, 1 bit: asserted once a first error has been captured.
REQ-015 SHALL have port FIRST_ERR_TYPE, output, 2 bits: index of the first error flag set.

Function
REQ-016 SHALL be passive; the bus is only observed, and every input except CLEAR is monitor-only.
REQ-017 SHALL define a beat as SRC_RDY=1 and DST_RDY=1; SOF, EOF and positions are ignored outside a beat.
REQ-018 SHALL keep a registered flag OPEN (packet in progress) and chain it through regions 0 to REGIONS-1 within a beat, with open_in of region 0 equal to OPEN.
REQ-019 SHALL let s denote SOF_POS*BLOCK_SIZE and e denote EOF_POS for the region.
REQ-020 SHALL apply these per-region rules when open_in=1: EOF only closes the packet; SOF with EOF and e<s closes then reopens; SOF with e>=s, or SOF alone, raises SOF_IN_PKT.
REQ-021 SHALL apply these per-region rules when open_in=0: SOF alone opens; SOF with EOF and e>=s is a single-region packet; EOF alone, or EOF with e<s, raises EOF_NO_PKT.
REQ-022 SHALL compute open_out as 1 if SOF is set and (EOF is clear or e<s), else 0 if EOF is set, else open_in; this resynchronises the checker after an error.
REQ-023 SHALL, on a beat, load OPEN with open_out of region REGIONS-1; OPEN SHALL hold otherwise.
REQ-024 SHALL raise HOLD when the previous cycle had SRC_RDY=1 and DST_RDY=0 and, in the current cycle, SRC_RDY=0 or any of DATA, META, SOF, EOF, SOF_POS or EOF_POS differs.
REQ-025 SHALL increment PKT_CNT by the number of EOFs in a beat, saturating at all-ones.
REQ-026 SHALL increment ERR_CNT by 1 per cycle with any error, saturating at all-ones.
REQ-027 SHALL, when several errors occur in the first error cycle, set FIRST_ERR_TYPE to the lowest flag index.
REQ-028 SHALL register all status outputs, so a beat in cycle N is reflected in cycle N+1.
REQ-029 SHALL, on CLEAR=1, zero the flags, counters and first-error capture in the next cycle; CLEAR SHALL take priority and discard errors and EOFs of that cycle.
REQ-030 SHALL NOT clear OPEN on CLEAR.

Reset
REQ-031 SHALL, with RESET_N=0 at a CLK edge, zero OPEN, ERR_FLAGS, ERR_CNT, PKT_CNT, FIRST_ERR_VLD, FIRST_ERR_TYPE and the hold-check history.
REQ-032 SHALL ignore the bus during reset.
REQ-033 SHALL NOT count a HOLD on the first cycle after reset release.
REQ-034 SHALL, when reset occurs mid-packet, drop the packet, so a following EOF without SOF raises EOF_NO_PKT.

Configuration
REQ-035 SHALL, with MFB_PROTOCOL_CHECKER_HOLD_CHECK_EN defined, implement REQ-024 including the history registers.
REQ-036 SHALL, without MFB_PROTOCOL_CHECKER_HOLD_CHECK_EN, contain no history registers and keep ERR_FLAGS[2] constant 0.

Verification
REQ-037 SHALL verify, for REGIONS=4, a beat with SOF in region 0 at SOF_POS=0 and EOF in region 2 at EOF_POS=63: no error flags, and PKT_CNT=1 in the next cycle.
REQ-038 SHALL verify a SOF in beat 1 followed by a SOF in beat 2 with no EOF between: ERR_FLAGS=0001, ERR_CNT=1, FIRST_ERR_VLD=1 and FIRST_ERR_TYPE=0.
REQ-039 SHALL verify one region with OPEN=0 and EOF at e=5 with SOF at SOF_POS=1 (s=8): ERR_FLAGS=0010, and OPEN=1 afterwards.
REQ-040 SHALL verify, with HOLD enabled, SRC_RDY=1 and DST_RDY=0 followed by DATA changing while DST_RDY stays 0: ERR_FLAGS[2]=1; without the macro the same stimulus gives ERR_FLAGS[2]=0.
REQ-041 SHALL verify CLEAR=1 asserted in the same cycle as a SOF_IN_PKT error: all status outputs read 0 in the next cycle.
REQ-042 SHALL verify, with CNT_WIDTH=4, 20 single-region packets: PKT_CNT saturates at 15.

Source files
------------

// File: rtl/mfb_protocol_checker.sv
// Passive MFB protocol checker: tracks packet framing across regions,
// flags SOF inside a packet, EOF without a packet and (optionally)
// bus changes while stalled, and keeps saturating error/packet counters.
// Optional feature macro: MFB_PROTOCOL_CHECKER_HOLD_CHECK_EN enables the
// stall-hold check and its history registers.
module mfb_protocol_checker #(
    parameter int unsigned REGIONS     = 4,
    parameter int unsigned REGION_SIZE = 8,
    parameter int unsigned BLOCK_SIZE  = 8,
    parameter int unsigned ITEM_WIDTH  = 8,
    parameter int unsigned META_WIDTH  = 0,
    parameter int unsigned CNT_WIDTH   = 32,
    localparam int unsigned DATA_W    = REGIONS * REGION_SIZE * BLOCK_SIZE * ITEM_WIDTH,
    localparam int unsigned META_RW   = (META_WIDTH > 0) ? META_WIDTH : 1,
    localparam int unsigned SOF_POS_W = (REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1,
    localparam int unsigned EOF_POS_W = (REGION_SIZE * BLOCK_SIZE > 1) ?
                                        $clog2(REGION_SIZE * BLOCK_SIZE) : 1
) (
    input  logic                           CLK,
    input  logic                           RESET_N,
    input  logic [DATA_W-1:0]              DATA,
    input  logic [REGIONS*META_RW-1:0]     META,
    input  logic [REGIONS-1:0]             SOF,
    input  logic [REGIONS-1:0]             EOF,
    input  logic [REGIONS*SOF_POS_W-1:0]   SOF_POS,
    input  logic [REGIONS*EOF_POS_W-1:0]   EOF_POS,
    input  logic                           SRC_RDY,
    input  logic                           DST_RDY,
    input  logic                           CLEAR,
    output logic [3:0]                     ERR_FLAGS,
    output logic [CNT_WIDTH-1:0]           ERR_CNT,
    output logic [CNT_WIDTH-1:0]           PKT_CNT,
    output logic                           FIRST_ERR_VLD,
    output logic [1:0]                     FIRST_ERR_TYPE
);

    localparam int unsigned EOF_CNT_W = $clog2(REGIONS + 1);

    logic                  open_q, open_d;
    logic [2:0]            flags_q, flags_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic                  first_vld_q, first_vld_d;
    logic [1:0]            first_type_q, first_type_d;

    logic                  beat_c;
    logic                  err_sof_c, err_eof_c, hold_c;
    logic [EOF_CNT_W-1:0]  eof_cnt_c;
    logic                  sof_v, eof_v;
    logic [EOF_POS_W-1:0]  s_v, e_v;
    logic [2:0]            err_c;
    logic                  any_err_c;
    logic [CNT_WIDTH:0]    pkt_sum_c;

    assign beat_c = SRC_RDY & DST_RDY;

    // Walk the open flag through the regions of a beat and collect framing errors
    always_comb begin
        open_d    = open_q;
        err_sof_c = 1'b0;
        err_eof_c = 1'b0;
        eof_cnt_c = '0;
        sof_v     = 1'b0;
        eof_v     = 1'b0;
        s_v       = '0;
        e_v       = '0;
        for (int unsigned r = 0; r < REGIONS; r++) begin
            sof_v = beat_c & SOF[r];
            eof_v = beat_c & EOF[r];
            s_v   = EOF_POS_W'(SOF_POS[r*SOF_POS_W +: SOF_POS_W]) * EOF_POS_W'(BLOCK_SIZE);
            e_v   = EOF_POS[r*EOF_POS_W +: EOF_POS_W];
            if (open_d) begin
                if (sof_v && (!eof_v || (e_v >= s_v))) err_sof_c = 1'b1;
            end else begin
                if (eof_v && (!sof_v || (e_v < s_v))) err_eof_c = 1'b1;
            end
            if (eof_v) eof_cnt_c = eof_cnt_c + EOF_CNT_W'(1);
            // Resynchronise on whatever framing the region shows, even after an error
            if (sof_v && (!eof_v || (e_v < s_v))) begin
                open_d = 1'b1;
            end else if (eof_v) begin
                open_d = 1'b0;
            end
        end
    end

`ifdef MFB_PROTOCOL_CHECKER_HOLD_CHECK_EN
    logic                          stall_q, stall_d;
    logic [DATA_W-1:0]             data_q, data_d;
    logic [REGIONS*META_RW-1:0]    meta_q, meta_d;
    logic [REGIONS-1:0]            sof_q, sof_d;
    logic [REGIONS-1:0]            eof_q, eof_d;
    logic [REGIONS*SOF_POS_W-1:0]  sof_pos_q, sof_pos_d;
    logic [REGIONS*EOF_POS_W-1:0]  eof_pos_q, eof_pos_d;

    // Capture the bus each cycle and flag a change or withdrawal while stalled
    always_comb begin
        stall_d   = SRC_RDY & ~DST_RDY;
        data_d    = DATA;
        meta_d    = META;
        sof_d     = SOF;
        eof_d     = EOF;
        sof_pos_d = SOF_POS;
        eof_pos_d = EOF_POS;
        hold_c    = stall_q && (!SRC_RDY || (DATA != data_q) ||
                    ((META_WIDTH != 0) && (META != meta_q)) ||
                    (SOF != sof_q) || (EOF != eof_q) ||
                    (SOF_POS != sof_pos_q) || (EOF_POS != eof_pos_q));
    end

    // Hold-check history; cleared by reset so the release cycle never flags
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            stall_q   <= 1'b0;
            data_q    <= '0;
            meta_q    <= '0;
            sof_q     <= '0;
            eof_q     <= '0;
            sof_pos_q <= '0;
            eof_pos_q <= '0;
        end else begin
            stall_q   <= stall_d;
            data_q    <= data_d;
            meta_q    <= meta_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            sof_pos_q <= sof_pos_d;
            eof_pos_q <= eof_pos_d;
        end
    end
`else
    logic unused_bus_c;
    assign unused_bus_c = ^{DATA, META};
    assign hold_c       = 1'b0;
`endif

    // Update sticky flags, saturating counters and first-error capture
    always_comb begin
        err_c        = {hold_c, err_eof_c, err_sof_c};
        any_err_c    = |err_c;
        pkt_sum_c    = {1'b0, pkt_cnt_q} + (CNT_WIDTH+1)'(eof_cnt_c);
        flags_d      = flags_q;
        err_cnt_d    = err_cnt_q;
        pkt_cnt_d    = pkt_cnt_q;
        first_vld_d  = first_vld_q;
        first_type_d = first_type_q;
        if (CLEAR) begin
            flags_d      = '0;
            err_cnt_d    = '0;
            pkt_cnt_d    = '0;
            first_vld_d  = 1'b0;
            first_type_d = '0;
        end else begin
            flags_d   = flags_q | err_c;
            pkt_cnt_d = pkt_sum_c[CNT_WIDTH] ? '1 : pkt_sum_c[CNT_WIDTH-1:0];
            if (any_err_c && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
            if (any_err_c && !first_vld_q) begin
                first_vld_d  = 1'b1;
                first_type_d = err_c[0] ? 2'd0 : (err_c[1] ? 2'd1 : 2'd2);
            end
        end
    end

    // State and status registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            open_q       <= 1'b0;
            flags_q      <= '0;
            err_cnt_q    <= '0;
            pkt_cnt_q    <= '0;
            first_vld_q  <= 1'b0;
            first_type_q <= '0;
        end else begin
            open_q       <= open_d;
            flags_q      <= flags_d;
            err_cnt_q    <= err_cnt_d;
            pkt_cnt_q    <= pkt_cnt_d;
            first_vld_q  <= first_vld_d;
            first_type_q <= first_type_d;
        end
    end

    assign ERR_FLAGS      = {1'b0, flags_q};
    assign ERR_CNT        = err_cnt_q;
    assign PKT_CNT        = pkt_cnt_q;
    assign FIRST_ERR_VLD  = first_vld_q;
    assign FIRST_ERR_TYPE = first_type_q;

endmodule

// File: tb/tb_mfb_protocol_checker.sv
// Directed scoreboard bench for mfb_protocol_checker (REGIONS=4, CNT_WIDTH=4).
module tb_mfb_protocol_checker;

    localparam int unsigned R   = 4;
    localparam int unsigned RS  = 8;
    localparam int unsigned BS  = 8;
    localparam int unsigned IW  = 8;
    localparam int unsigned CW  = 4;
    localparam int unsigned SPW = 3;
    localparam int unsigned EPW = 6;
`ifdef MFB_PROTOCOL_CHECKER_HOLD_CHECK_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [R*RS*BS*IW-1:0] data;
    logic [R-1:0]         meta;
    logic [R-1:0]         sof, eof;
    logic [R*SPW-1:0]     sof_pos;
    logic [R*EPW-1:0]     eof_pos;
    logic                 src_rdy, dst_rdy, clear;
    logic [3:0]           err_flags;
    logic [CW-1:0]        err_cnt, pkt_cnt;
    logic                 first_err_vld;
    logic [1:0]           first_err_type;

    always #5 clk = ~clk;

    mfb_protocol_checker #(
        .REGIONS(R), .REGION_SIZE(RS), .BLOCK_SIZE(BS), .ITEM_WIDTH(IW),
        .META_WIDTH(0), .CNT_WIDTH(CW)
    ) dut (
        .CLK(clk), .RESET_N(reset_n), .DATA(data), .META(meta),
        .SOF(sof), .EOF(eof), .SOF_POS(sof_pos), .EOF_POS(eof_pos),
        .SRC_RDY(src_rdy), .DST_RDY(dst_rdy), .CLEAR(clear),
        .ERR_FLAGS(err_flags), .ERR_CNT(err_cnt), .PKT_CNT(pkt_cnt),
        .FIRST_ERR_VLD(first_err_vld), .FIRST_ERR_TYPE(first_err_type)
    );

    typedef struct {
        logic [3:0]    flags;
        logic [CW-1:0] ecnt;
        logic [CW-1:0] pcnt;
        logic          vld;
        logic [1:0]    ftype;
    } exp_t;

    exp_t  sb[$];
    string tags[$];
    exp_t  e;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input string f, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, f, obs, expv);
        end
    endtask

    // Push the expectation, clock one edge, then pop and compare the registered status
    task automatic step(input string tag);
        exp_t  x;
        string t;
        sb.push_back(e);
        tags.push_back(tag);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        t = tags.pop_front();
        chk(t, "err_flags", 32'(err_flags), 32'(x.flags));
        chk(t, "err_cnt", 32'(err_cnt), 32'(x.ecnt));
        chk(t, "pkt_cnt", 32'(pkt_cnt), 32'(x.pcnt));
        chk(t, "first_vld", 32'(first_err_vld), 32'(x.vld));
        chk(t, "first_type", 32'(first_err_type), 32'(x.ftype));
        @(negedge clk);
    endtask

    task automatic idle();
        sof = '0; eof = '0; sof_pos = '0; eof_pos = '0; meta = '0;
        src_rdy = 1'b0; dst_rdy = 1'b0; clear = 1'b0;
    endtask

    task automatic beat();
        src_rdy = 1'b1; dst_rdy = 1'b1;
    endtask

    task automatic set_reg(input int r, input logic s, input int sp, input logic en, input int ep);
        sof[r] = s;
        sof_pos[r*SPW +: SPW] = SPW'(sp);
        eof[r] = en;
        eof_pos[r*EPW +: EPW] = EPW'(ep);
    endtask

    task automatic clr_exp();
        e.flags = '0; e.ecnt = '0; e.pcnt = '0; e.vld = 1'b0; e.ftype = '0;
    endtask

    task automatic bump_err();
        if (e.ecnt != {CW{1'b1}}) e.ecnt = e.ecnt + CW'(1);
    endtask

    task automatic bump_pkt(input int n);
        int s;
        s = int'(e.pcnt) + n;
        e.pcnt = (s > 15) ? CW'(15) : CW'(s);
    endtask

    task automatic first(input logic [1:0] t);
        if (!e.vld) begin
            e.vld = 1'b1;
            e.ftype = t;
        end
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        data = {64{32'hA5A5_1234}};
        idle();
        reset_n = 1'b0;
        clr_exp();
        step("reset0");
        step("reset1");
        reset_n = 1'b1;
        step("idle0");

        // Packet spanning regions 0..2 in one beat
        idle(); set_reg(0, 1, 0, 0, 0); set_reg(2, 0, 0, 1, 63); beat(); bump_pkt(1);
        step("single_beat_pkt");
        idle(); step("idle_after_pkt");

        // SOF then SOF with no EOF between
        idle(); set_reg(0, 1, 0, 0, 0); beat(); step("sof_open");
        idle(); set_reg(0, 1, 0, 0, 0); beat(); e.flags |= 4'b0001; bump_err(); first(2'd0);
        step("sof_in_pkt");

        // CLEAR zeroes status but keeps the packet open; CLEAR wins over a same-cycle error
        idle(); clear = 1'b1; clr_exp(); step("clear_idle");
        idle(); clear = 1'b1; set_reg(0, 1, 0, 0, 0); beat(); step("clear_wins");
        idle(); set_reg(0, 0, 0, 1, 5); beat(); bump_pkt(1); step("eof_close");

        // EOF before SOF in one region while closed: error, then packet is open
        idle(); set_reg(0, 1, 1, 1, 5); beat(); e.flags |= 4'b0010; bump_err(); first(2'd1); bump_pkt(1);
        step("eof_no_pkt_e_lt_s");
        idle(); set_reg(0, 1, 0, 0, 0); beat(); e.flags |= 4'b0001; bump_err();
        step("open_after_e_lt_s");

        // Two error kinds in one beat: lowest index wins, one error cycle counted
        idle(); clear = 1'b1; clr_exp(); step("clear2");
        idle(); set_reg(0, 1, 0, 0, 0); set_reg(1, 0, 0, 1, 0); set_reg(2, 0, 0, 1, 9); beat();
        e.flags |= 4'b0011; bump_err(); first(2'd0); bump_pkt(2);
        step("multi_err");

        // Stall followed by a data change, then withdrawal of SRC_RDY
        idle(); clear = 1'b1; clr_exp(); step("clear3");
        idle(); src_rdy = 1'b1; set_reg(0, 0, 0, 1, 3); step("stall_no_beat");
        idle(); src_rdy = 1'b1; set_reg(0, 0, 0, 1, 3); data[0] = ~data[0];
        if (HOLD_EN) begin e.flags |= 4'b0100; bump_err(); first(2'd2); end
        step("hold_data_change");
        idle(); if (HOLD_EN) bump_err(); step("hold_src_drop");
        idle(); step("hold_none");

        // Reset mid-packet drops it; release cycle raises no hold
        idle(); clear = 1'b1; clr_exp(); step("clear4");
        idle(); set_reg(0, 1, 0, 0, 0); beat(); step("open_before_reset");
        idle(); reset_n = 1'b0; src_rdy = 1'b1; set_reg(0, 0, 0, 1, 3); step("reset_mid");
        idle(); reset_n = 1'b1; step("no_hold_after_reset");
        idle(); set_reg(0, 0, 0, 1, 3); beat(); e.flags |= 4'b0010; bump_err(); first(2'd1); bump_pkt(1);
        step("eof_after_reset");

        // Counter saturation
        idle(); clear = 1'b1; clr_exp(); step("clear5");
        for (int i = 0; i < 20; i++) begin
            idle(); set_reg(0, 1, 0, 1, 7); beat(); bump_pkt(1);
            step($sformatf("pkt_sat%0d", i));
        end
        for (int i = 0; i < 17; i++) begin
            idle(); set_reg(0, 0, 0, 1, 7); beat(); e.flags |= 4'b0010; bump_err(); first(2'd1); bump_pkt(1);
            step($sformatf("err_sat%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
